// File: rtl/acumulador_pkg.sv
// Shared encodings for the 7-bit accumulator controller and its overflow detector.
package acumulador_pkg;

   localparam int W_DEFAULT = 7;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/detector_overflow7b.sv
// Combinational W+1-bit signed add/sub of accumulator and operand; flags signed overflow.
module detector_overflow7b
   import acumulador_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic         ovf_now
);

   logic [W:0] a_ext;
   logic [W:0] b_ext;
   logic [W:0] sum;

   assign a_ext = {a[W-1], a};
   assign b_ext = {b[W-1], b};
   assign sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);

   // The two top bits disagree exactly when the true result leaves the W-bit range.
   assign ovf_now = sum[W] ^ sum[W-1];

endmodule

// File: rtl/controlador_acumulador7b.sv
// Sequencer driving the add/sub accumulator datapath for ADD/SUB/CLR/MUL commands.
// Define ACC_OVF_ABORT_EN to stop a command on the first overflowing iteration.
module controlador_acumulador7b
   import acumulador_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [W-1:0]     cmd_operand,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [W-1:0]     acc_q,
   output logic             acc_sinal,
   output logic [W-1:0]     acc_b,
   output logic             acc_cin,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state;
   logic [1:0]       op_q;
   logic [W-1:0]     operand_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_now;
   logic             last_run;

   detector_overflow7b #(.W(W)) u_detector (
      .a       (acc_q),
      .b       (operand_q),
      .sub     (op_q == OP_SUB),
      .ovf_now (ovf_now)
   );

`ifdef ACC_OVF_ABORT_EN
   assign last_run = (cnt_q == CNT_ONE) || ovf_now;
`else
   assign last_run = (cnt_q == CNT_ONE);
`endif

   // MUL reuses the RUN loop as repeated ADD after a one-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= OP_ADD;
         operand_q <= '0;
         cnt_q     <= '0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q      <= cmd_op;
                  operand_q <= cmd_operand;
                  cnt_q     <= cmd_count;
                  ovf       <= 1'b0;
                  if (cmd_op == OP_CLR || cmd_op == OP_MUL)
                     state <= ST_CLEAR;
                  else if (cmd_count == '0)
                     state <= ST_DONE;
                  else
                     state <= ST_RUN;
               end
            end
            ST_CLEAR: begin
               if (op_q == OP_MUL && cnt_q != '0) begin
                  op_q  <= OP_ADD;
                  state <= ST_RUN;
               end else begin
                  state <= ST_DONE;
               end
            end
            ST_RUN: begin
               if (ovf_now)
                  ovf <= 1'b1;
               cnt_q <= cnt_q - CNT_ONE;
               if (last_run)
                  state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath has no enable: holding means adding zero, clearing means subtracting Q from itself.
   always_comb begin
      acc_sinal = 1'b0;
      acc_b     = '0;
      case (state)
         ST_CLEAR: begin
            acc_sinal = 1'b1;
            acc_b     = acc_q;
         end
         ST_RUN: begin
            acc_sinal = (op_q == OP_SUB);
            acc_b     = operand_q;
`ifdef ACC_OVF_ABORT_EN
            if (ovf_now) begin
               acc_sinal = 1'b0;
               acc_b     = '0;
            end
`endif
         end
         default: begin
            acc_sinal = 1'b0;
            acc_b     = '0;
         end
      endcase
   end

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign acc_cin   = 1'b0;

endmodule

// File: tb/tb_controlador_acumulador7b.sv
// Scoreboard bench for controlador_acumulador7b with a behavioural accumulator datapath.
// Honours ACC_OVF_ABORT_EN the same way the design does.
module tb_controlador_acumulador7b;
   import acumulador_pkg::*;

   localparam int W     = 7;
   localparam int CNT_W = 4;

`ifdef ACC_OVF_ABORT_EN
   localparam logic [W-1:0] ADD_OVF_Q   = 7'd40;
   localparam int           ADD_OVF_LAT = 3;
`else
   localparam logic [W-1:0] ADD_OVF_Q   = 7'h78;
   localparam int           ADD_OVF_LAT = 4;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = OP_ADD;
   logic [W-1:0]     cmd_operand = '0;
   logic [CNT_W-1:0] cmd_count = '0;
   logic [W-1:0]     acc_q = 7'h2A;
   logic             acc_sinal;
   logic [W-1:0]     acc_b;
   logic             acc_cin;
   logic             busy;
   logic             done;
   logic             ovf;

   typedef struct {
      logic [W-1:0] q;
      logic         ovf;
      int           due;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   dp_live = 1'b0;

   controlador_acumulador7b #(.W(W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_operand (cmd_operand),
      .cmd_count   (cmd_count),
      .acc_q       (acc_q),
      .acc_sinal   (acc_sinal),
      .acc_b       (acc_b),
      .acc_cin     (acc_cin),
      .busy        (busy),
      .done        (done),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;

   // Behavioural datapath: no reset, no enable; skips the very first edge while the FSM is still unknown.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (dp_live)
         acc_q <= acc_sinal ? (acc_q - acc_b) : (acc_q + acc_b + {{(W-1){1'b0}}, acc_cin});
      dp_live <= 1'b1;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_done", int'(done), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput({e.name, "_acc_q"}, int'(acc_q), int'(e.q));
            checkOutput({e.name, "_ovf"}, int'(ovf), int'(e.ovf));
            checkOutput({e.name, "_latency_cycle"}, cyc, e.due);
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] operand,
                                input logic [CNT_W-1:0] count, input bit expect_done,
                                input logic [W-1:0] exp_q, input logic exp_ovf,
                                input int exp_lat, input string name);
      exp_t e;
      int   n;
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_operand = operand;
      cmd_count   = count;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (cmd_ready !== 1'b1)
         checkOutput({name, "_accept_timeout"}, int'(cmd_ready), 1);
      if (expect_done) begin
         e.q    = exp_q;
         e.ovf  = exp_ovf;
         e.due  = cyc + exp_lat;
         e.name = name;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy === 1'b0)
            return;
      end
      checkOutput({name, "_idle_timeout"}, int'(busy), 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int busy_n;

      // Reset state; the accumulator keeps whatever it held.
      repeat (3) @(negedge clk);
      checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_ovf", int'(ovf), 0);
      checkOutput("rst_acc_sinal", int'(acc_sinal), 0);
      checkOutput("rst_acc_b", int'(acc_b), 0);
      checkOutput("rst_acc_cin", int'(acc_cin), 0);
      checkOutput("rst_acc_q_held", int'(acc_q), 'h2A);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(OP_CLR, 7'd0, 4'd0, 1'b1, 7'd0, 1'b0, 2, "clr1");
      waitIdle("clr1");

      applyStimulus(OP_MUL, 7'd5, 4'd6, 1'b1, 7'd30, 1'b0, 8, "mul");
      waitIdle("mul");

      // SUB with a stray command pulsed mid-run that must not be taken.
      applyStimulus(OP_SUB, 7'd7, 4'd3, 1'b1, 7'd9, 1'b0, 4, "sub");
      busy_n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (busy !== 1'b1)
            break;
         busy_n++;
         if (busy_n == 2) begin
            checkOutput("sub_ready_while_busy", int'(cmd_ready), 0);
            cmd_op    = OP_CLR;
            cmd_valid = 1'b1;
         end
      end
      checkOutput("sub_busy_cycles", busy_n, 4);
      checkOutput("sub_acc_q_after", int'(acc_q), 9);

      applyStimulus(OP_CLR, 7'd0, 4'd0, 1'b1, 7'd0, 1'b0, 2, "clr2");
      waitIdle("clr2");

      applyStimulus(OP_ADD, 7'd40, 4'd3, 1'b1, ADD_OVF_Q, 1'b1, ADD_OVF_LAT, "add_ovf");
      waitIdle("add_ovf");

      applyStimulus(OP_ADD, 7'd5, 4'd0, 1'b1, ADD_OVF_Q, 1'b0, 1, "add_cnt0");
      waitIdle("add_cnt0");

      applyStimulus(OP_CLR, 7'd0, 4'd0, 1'b1, 7'd0, 1'b0, 2, "clr3");
      waitIdle("clr3");

      // Reset during the third RUN cycle of ADD 1 x10: no done, partial sum kept.
      applyStimulus(OP_ADD, 7'd1, 4'd10, 1'b0, 7'd0, 1'b0, 0, "add_rst");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_cmd_ready", int'(cmd_ready), 1);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_acc_b", int'(acc_b), 0);
      checkOutput("midrst_ovf", int'(ovf), 0);
      checkOutput("midrst_done", int'(done), 0);
      checkOutput("midrst_acc_q", int'(acc_q), 3);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("midrst_acc_q_held", int'(acc_q), 3);
      checkOutput("midrst_idle", int'(cmd_ready), 1);

      checkOutput("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
